// File: rtl/irs_event_buffer.sv
// Event word buffer: 16-bit writes in, packed 32-bit pairs out (first-word-fall-through).
// Optional dropped-word counter on ovf_cnt_o is built when IRS_EVENT_BUFFER_OVFCNT_EN is defined.
module irs_event_buffer #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] event_dat_i,
    input  logic        event_wr_i,
    output logic [15:0] event_cnt_o,
    input  logic        flush_i,
    output logic [31:0] out_dat_o,
    output logic        out_valid_o,
    input  logic        out_rd_i,
    output logic        empty_o,
    output logic        ovf_o,
    output logic [7:0]  ovf_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = DEPTH_LOG2 + 1;

    typedef enum logic {ST_EMPTY, ST_LOADED} state_t;

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [FW-1:0]         fill_reg, fill_next, unread_next;
    logic                  avail_reg, avail_next;
    logic                  ovf_reg, ovf_next;
    logic                  empty_reg;
    logic [15:0]           event_cnt_reg;
    logic [31:0]           out_dat_reg;
    logic                  wr_ok, wr_drop, pop, load;
    logic [15:0]           rd_word [2];

    assign wr_ok   = event_wr_i && !flush_i && (fill_reg < FW'(DEPTH));
    assign wr_drop = event_wr_i && !flush_i && (fill_reg == FW'(DEPTH));
    assign pop     = out_rd_i && !flush_i && (state_reg == ST_LOADED);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (avail_reg) begin
                    load       = 1'b1;
                    state_next = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (pop) begin
                    if (avail_reg) load = 1'b1;
                    else           state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_next = ST_EMPTY;
            load       = 1'b0;
        end
    end

    // avail excludes the word written on this edge: the prefetch read cannot see it yet.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(wr_ok);
        rd_ptr_next = rd_ptr_reg + (load ? DEPTH_LOG2'(2) : DEPTH_LOG2'(0));
        fill_next   = fill_reg + FW'(wr_ok) - (pop ? FW'(2) : FW'(0));
        unread_next = fill_reg - ((state_reg == ST_LOADED) ? FW'(2) : FW'(0))
                               - (load ? FW'(2) : FW'(0));
        avail_next  = (unread_next >= FW'(2));
        ovf_next    = ovf_reg | wr_drop;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            fill_next   = '0;
            avail_next  = 1'b0;
            ovf_next    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_EMPTY;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fill_reg      <= '0;
            avail_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            empty_reg     <= 1'b1;
            event_cnt_reg <= 16'(DEPTH);
            out_dat_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            fill_reg      <= fill_next;
            avail_reg     <= avail_next;
            ovf_reg       <= ovf_next;
            empty_reg     <= (fill_next == '0);
            event_cnt_reg <= 16'(DEPTH - int'(fill_next));
            if (load) out_dat_reg <= {rd_word[1], rd_word[0]};
        end
    end

    // Even/odd word banks; pairs never straddle banks since rd_ptr stays even.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_bank
        logic [15:0] mem [DEPTH/2];
        logic [15:0] rd_word_reg;

        always_ff @(posedge clk_i) begin
            if (wr_ok && (wr_ptr_reg[0] == 1'(gi)))
                mem[wr_ptr_reg[DEPTH_LOG2-1:1]] <= event_dat_i;
            rd_word_reg <= mem[rd_ptr_next[DEPTH_LOG2-1:1]];
        end

        assign rd_word[gi] = rd_word_reg;
    end

`ifdef IRS_EVENT_BUFFER_OVFCNT_EN
    logic [7:0] ovf_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ovf_cnt_reg <= '0;
        else if (flush_i)
            ovf_cnt_reg <= '0;
        else if (wr_drop && (ovf_cnt_reg != 8'hFF))
            ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
    end

    assign ovf_cnt_o = ovf_cnt_reg;
`else
    assign ovf_cnt_o = 8'd0;
`endif

    assign out_valid_o = (state_reg == ST_LOADED);
    assign out_dat_o   = out_dat_reg;
    assign event_cnt_o = event_cnt_reg;
    assign empty_o     = empty_reg;
    assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_irs_event_buffer.sv
// Bench for irs_event_buffer: a 1024-deep and a 16-deep instance share one stimulus and are
// both checked every cycle against a word-queue model, plus directed literal checks.
module tb_irs_event_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] event_dat_i = '0;
    logic        event_wr_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        out_rd_i = 1'b0;

    logic [15:0] cnt_l, cnt_s;
    logic [31:0] dat_l, dat_s;
    logic        val_l, val_s, emp_l, emp_s, ovf_l, ovf_s;
    logic [7:0]  oc_l, oc_s;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    irs_event_buffer #(.DEPTH_LOG2(10)) dut_l (
        .clk_i(clk_i), .rst_i(rst_i), .event_dat_i(event_dat_i), .event_wr_i(event_wr_i),
        .event_cnt_o(cnt_l), .flush_i(flush_i), .out_dat_o(dat_l), .out_valid_o(val_l),
        .out_rd_i(out_rd_i), .empty_o(emp_l), .ovf_o(ovf_l), .ovf_cnt_o(oc_l)
    );

    irs_event_buffer #(.DEPTH_LOG2(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .event_dat_i(event_dat_i), .event_wr_i(event_wr_i),
        .event_cnt_o(cnt_s), .flush_i(flush_i), .out_dat_o(dat_s), .out_valid_o(val_s),
        .out_rd_i(out_rd_i), .empty_o(emp_s), .ovf_o(ovf_s), .ovf_cnt_o(oc_s)
    );

    always #5 clk_i = ~clk_i;

`ifdef IRS_EVENT_BUFFER_OVFCNT_EN
    localparam bit OVFCNT_EN = 1'b1;
`else
    localparam bit OVFCNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word gets an absolute index and the edge number it was written on.
    logic [15:0] wd [2][8192];
    int          ws [2][8192];
    int          acc [2];
    int          cons [2];
    int          fill [2];
    int          ovfc [2];
    bit          mvalid [2];
    bit          movf [2];
    logic [31:0] mdat [2];

    function automatic int depth_of(input int m);
        return (m == 0) ? 1024 : 16;
    endfunction

    task automatic model_reset(input int m);
        cons[m]   = acc[m];
        fill[m]   = 0;
        ovfc[m]   = 0;
        mvalid[m] = 1'b0;
        movf[m]   = 1'b0;
        mdat[m]   = '0;
    endtask

    task automatic model_edge(input int m, input bit w, input logic [15:0] d,
                              input bit r, input bit f, input int c);
        bit popped;
        if (f) begin
            cons[m]   = acc[m];
            fill[m]   = 0;
            ovfc[m]   = 0;
            mvalid[m] = 1'b0;
            movf[m]   = 1'b0;
        end else begin
            popped = r && mvalid[m];
            if (w && fill[m] < depth_of(m)) begin
                wd[m][acc[m] % 8192] = d;
                ws[m][acc[m] % 8192] = c;
                acc[m]++;
                fill[m]++;
            end else if (w) begin
                movf[m] = 1'b1;
                if (ovfc[m] < 255) ovfc[m]++;
            end
            if (popped) begin
                fill[m]  -= 2;
                mvalid[m] = 1'b0;
                if (m == 0 && verbose) $display("pop pair %h at t=%0t", mdat[m], $time);
            end
            // A pair becomes visible two edges after its second word was written.
            if (!mvalid[m] && (acc[m] - cons[m]) >= 2 && ws[m][(cons[m] + 1) % 8192] <= c - 2) begin
                mdat[m]   = {wd[m][(cons[m] + 1) % 8192], wd[m][cons[m] % 8192]};
                cons[m]  += 2;
                mvalid[m] = 1'b1;
            end
        end
    endtask

    task automatic compare(input int m);
        logic        v, e, o;
        logic [31:0] dd;
        logic [15:0] cc;
        logic [7:0]  oc;
        v  = (m == 0) ? val_l : val_s;
        e  = (m == 0) ? emp_l : emp_s;
        o  = (m == 0) ? ovf_l : ovf_s;
        dd = (m == 0) ? dat_l : dat_s;
        cc = (m == 0) ? cnt_l : cnt_s;
        oc = (m == 0) ? oc_l : oc_s;
        chk($sformatf("m%0d out_valid", m), 32'(v), 32'(mvalid[m]));
        if (mvalid[m]) chk($sformatf("m%0d out_dat", m), dd, mdat[m]);
        chk($sformatf("m%0d event_cnt", m), 32'(cc), 32'(depth_of(m) - fill[m]));
        chk($sformatf("m%0d empty", m), 32'(e), 32'(fill[m] == 0));
        chk($sformatf("m%0d ovf", m), 32'(o), 32'(movf[m]));
        chk($sformatf("m%0d ovf_cnt", m), 32'(oc), OVFCNT_EN ? 32'(ovfc[m]) : 32'd0);
    endtask

    bit          s_rst, s_wr, s_rd, s_fl;
    logic [15:0] s_dat;
    int          cyc = 0;

    initial begin
        for (int m = 0; m < 2; m++) begin
            acc[m] = 0;
            model_reset(m);
        end
        forever begin
            @(posedge clk_i);
            s_rst = rst_i; s_wr = event_wr_i; s_rd = out_rd_i; s_fl = flush_i; s_dat = event_dat_i;
            cyc++;
            @(negedge clk_i);
            for (int m = 0; m < 2; m++) begin
                if (s_rst || rst_i) model_reset(m);
                else model_edge(m, s_wr, s_dat, s_rd, s_fl, cyc);
                compare(m);
            end
        end
    end

    task automatic put(input bit w, input logic [15:0] d, input bit r, input bit f);
        event_wr_i  = w;
        event_dat_i = d;
        out_rd_i    = r;
        flush_i     = f;
        @(posedge clk_i);
        #1;
        event_wr_i = 1'b0;
        out_rd_i   = 1'b0;
        flush_i    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_w;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst event_cnt", 32'(cnt_l), 32'd1024);
        chk("rst empty", 32'(emp_l), 32'd1);
        chk("rst valid", 32'(val_l), 32'd0);
        chk("rst out_dat", dat_l, 32'd0);
        chk("rst ovf_cnt", 32'(oc_s), 32'd0);

        // Two words, first accepted on the first edge after reset release.
        put(1, 16'h1111, 0, 0);
        put(1, 16'h2222, 0, 0);
        put(0, 16'h0, 0, 0);
        chk("lat edge+1 valid", 32'(val_l), 32'd0);
        put(0, 16'h0, 0, 0);
        chk("lat edge+2 valid", 32'(val_l), 32'd1);
        chk("lat out_dat", dat_l, 32'h22221111);
        chk("lat event_cnt", 32'(cnt_l), 32'd1022);

        // Three words: one pair out, one word waiting for its partner.
        put(0, 16'h0, 0, 1);
        put(1, 16'hAAA1, 0, 0);
        put(1, 16'hAAA2, 0, 0);
        put(1, 16'hAAA3, 0, 0);
        repeat (3) put(0, 16'h0, 0, 0);
        chk("odd valid", 32'(val_l), 32'd1);
        chk("odd out_dat", dat_l, 32'hAAA2AAA1);
        chk("odd event_cnt", 32'(cnt_l), 32'd1021);
        put(0, 16'h0, 1, 0);
        chk("odd pop valid", 32'(val_l), 32'd0);
        chk("odd pop event_cnt", 32'(cnt_l), 32'd1023);
        chk("odd pop empty", 32'(emp_l), 32'd0);
        put(1, 16'hAAA4, 0, 0);
        repeat (2) put(0, 16'h0, 0, 0);
        chk("partner out_dat", dat_l, 32'hAAA4AAA3);
        put(0, 16'h0, 1, 0);
        chk("drain empty", 32'(emp_l), 32'd1);
        chk("drain event_cnt", 32'(cnt_l), 32'd1024);

        // Overflow the 16-deep instance with 20 words.
        put(0, 16'h0, 0, 1);
        for (int i = 0; i < 20; i++) put(1, 16'hA000 + 16'(i), 0, 0);
        repeat (2) put(0, 16'h0, 0, 0);
        chk("ovf small event_cnt", 32'(cnt_s), 32'd0);
        chk("ovf small ovf", 32'(ovf_s), 32'd1);
        chk("ovf small ovf_cnt", 32'(oc_s), OVFCNT_EN ? 32'd4 : 32'd0);
        chk("ovf large event_cnt", 32'(cnt_l), 32'd1004);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf pair%0d valid", k), 32'(val_s), 32'd1);
            chk($sformatf("ovf pair%0d", k), dat_s,
                {16'hA000 + 16'(2 * k + 1), 16'hA000 + 16'(2 * k)});
            put(0, 16'h0, 1, 0);
        end
        chk("ovf drained empty", 32'(emp_s), 32'd1);
        chk("ovf sticky", 32'(ovf_s), 32'd1);

        // Flush beats a same-cycle write and pop.
        put(1, 16'hBEEF, 1, 1);
        chk("flush event_cnt", 32'(cnt_l), 32'd1024);
        chk("flush valid", 32'(val_l), 32'd0);
        chk("flush empty", 32'(emp_l), 32'd1);
        chk("flush small ovf", 32'(ovf_s), 32'd0);
        chk("flush small event_cnt", 32'(cnt_s), 32'd16);
        chk("flush small ovf_cnt", 32'(oc_s), 32'd0);

        // Streaming across three wraps of the large buffer, popping every other cycle.
        verbose = 1'b0;
        exp_w = 0;
        for (int i = 0; i < 3200; i++) begin
            if ((i % 2) == 1 && val_l) begin
                chk("wrap order", dat_l, {16'(exp_w + 1), 16'(exp_w)});
                exp_w += 2;
            end
            put(1, 16'(i), (i % 2) == 1, 0);
        end
        verbose = 1'b1;
        chk("wrap progress", 32'(exp_w >= 3072), 32'd1);
        chk("wrap ovf", 32'(ovf_l), 32'd0);

        // Asynchronous reset while a pair is loaded.
        put(0, 16'h0, 0, 1);
        put(1, 16'h5555, 0, 0);
        put(1, 16'h6666, 0, 0);
        repeat (3) put(0, 16'h0, 0, 0);
        chk("pre-rst valid", 32'(val_l), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async rst valid", 32'(val_l), 32'd0);
        chk("async rst small valid", 32'(val_s), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("post-rst event_cnt", 32'(cnt_l), 32'd1024);
        chk("post-rst empty", 32'(emp_l), 32'd1);
        repeat (3) put(0, 16'h0, 0, 0);
        chk("post-rst still empty", 32'(val_l), 32'd0);

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
